// File: rtl/hvsync_pkg.sv
// Raster timing constants and coordinate type for the 800x480 panel generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hvsync_pkg;

    // Default panel timing, in pixel clocks (horizontal) and lines (vertical)
    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 210;
    localparam int DEF_H_SYNC   = 30;
    localparam int DEF_H_BACK   = 16;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 22;
    localparam int DEF_V_SYNC   = 13;
    localparam int DEF_V_BACK   = 10;

    // Derived default geometry
    localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    // Screen coordinates are 12-bit unsigned
    localparam int COORD_W = 12;
    typedef logic [COORD_W-1:0] coord_t;

    // A timing set is usable when every interval is non-empty and the
    // whole period fits the coordinate width
    function automatic bit timing_ok(input int act, input int front,
                                     input int sync, input int back);
        return (act > 0) && (front > 0) && (sync > 0) && (back > 0) &&
               ((act + front + sync + back) <= (1 << COORD_W));
    endfunction

endpackage

// File: rtl/hvsync_if.sv
// Video timing bundle: pixel coordinates, syncs and data enable (frame_start with HVSYNC_FRAME_PULSE_EN).
// Latency: n/a (wires only).
// Backpressure: none; the raster free-runs and consumers must keep up.
interface hvsync_if;
    import hvsync_pkg::*;

    coord_t hpos;
    coord_t vpos;
    logic   hsync;
    logic   vsync;
    logic   data_enable;
`ifdef HVSYNC_FRAME_PULSE_EN
    logic   frame_start;
`endif

`ifdef HVSYNC_FRAME_PULSE_EN
    modport master (output hpos, vpos, hsync, vsync, data_enable, frame_start);
    modport slave  (input  hpos, vpos, hsync, vsync, data_enable, frame_start);
`else
    modport master (output hpos, vpos, hsync, vsync, data_enable);
    modport slave  (input  hpos, vpos, hsync, vsync, data_enable);
`endif

endinterface

// File: rtl/hvsync_axis.sv
// One raster axis: modulo counter with enable, wrap flag and next-state active/sync decode.
// Latency: pos registered; wrap and *_nxt are combinational from the current count.
// Backpressure: none; advances whenever en is high.
module hvsync_axis
    import hvsync_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output coord_t pos,
    output logic   wrap,
    output logic   active_nxt,
    output logic   sync_nxt
);

    localparam int     TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END    = coord_t'(ACTIVE);
    localparam coord_t SYNC_FIRST = coord_t'(ACTIVE + FRONT);
    localparam coord_t SYNC_LAST  = coord_t'(ACTIVE + FRONT + SYNC - 1);

    if (!timing_ok(ACTIVE, FRONT, SYNC, BACK)) begin : g_bad_timing
        $error("hvsync_axis: zero-length interval or period exceeds 12-bit coordinates");
    end

    coord_t pos_nxt;

    // Wrap flag tells the next axis that this one rolls over on the coming edge
    assign wrap = en && (pos == LAST);

    // Next count: hold, increment, or roll back to 0 after the last position
    always_comb begin
        pos_nxt = pos;
        if (en) begin
            pos_nxt = (pos == LAST) ? '0 : pos + coord_t'(1);
        end
    end

    // Region decode on the next count so registered flags line up with pos
    assign active_nxt = (pos_nxt < ACT_END);
    assign sync_nxt   = (pos_nxt >= SYNC_FIRST) && (pos_nxt <= SYNC_LAST);

    // Counter parks at the last position in reset so the first free edge lands on 0
    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= LAST;
        end else begin
            pos <= pos_nxt;
        end
    end

endmodule

// File: rtl/hvsync_gen.sv
// Raster timing generator for the 800x480 panel: hpos/vpos, HSYNC, VSYNC, data enable; optional frame_start via HVSYNC_FRAME_PULSE_EN.
// Latency: all outputs registered and mutually aligned to the same coordinate.
// Backpressure: none; free-runs one pixel per clk.
module hvsync_gen
    import hvsync_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic     clk,
    input  logic     reset,
    hvsync_if.master vid
);

    // Level a sync line sits at when not asserted
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    coord_t h_pos;
    coord_t v_pos;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_active_nxt;
    logic   v_active_nxt;
    logic   h_sync_nxt;
    logic   v_sync_nxt;

    hvsync_axis #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (1'b1),
        .pos        (h_pos),
        .wrap       (h_wrap),
        .active_nxt (h_active_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    hvsync_axis #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .pos        (v_pos),
        .wrap       (v_wrap),
        .active_nxt (v_active_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    assign vid.hpos = h_pos;
    assign vid.vpos = v_pos;

    // Syncs and enable registered from next-state decode so they match hpos/vpos
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.hsync       <= SYNC_IDLE;
            vid.vsync       <= SYNC_IDLE;
            vid.data_enable <= 1'b0;
        end else begin
            vid.hsync       <= h_sync_nxt ? ~SYNC_IDLE : SYNC_IDLE;
            vid.vsync       <= v_sync_nxt ? ~SYNC_IDLE : SYNC_IDLE;
            vid.data_enable <= h_active_nxt && v_active_nxt;
        end
    end

`ifdef HVSYNC_FRAME_PULSE_EN
    // Both axes rolling over together means the next coordinate is (0,0)
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.frame_start <= 1'b0;
        end else begin
            vid.frame_start <= h_wrap && v_wrap;
        end
    end
`else
    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_hvsync_gen.sv
// Bench: default-timing active-low generator plus a shrunken active-high one for frame-level checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_hvsync_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    hvsync_if u_if_a ();
    hvsync_if u_if_b ();

    // Full-size panel timing, active-low syncs
    hvsync_gen dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vid   (u_if_a)
    );

    // Shrunken raster: H_TOTAL 16 (sync 11..12), V_TOTAL 12 (sync 8..10), active-high
    hvsync_gen #(
        .H_ACTIVE        (8),
        .H_FRONT         (3),
        .H_SYNC          (2),
        .H_BACK          (3),
        .V_ACTIVE        (6),
        .V_FRONT         (2),
        .V_SYNC          (3),
        .V_BACK          (1),
        .SYNC_ACTIVE_LOW (0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vid   (u_if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a_pos_err, a_de_cnt, a_de_last, a_hs_cnt, a_hs_first, a_hs_last, a_vs_cnt;
        int b_pos_err, b_hs_err, b_hs_cnt, b_vs_err, b_vs_cnt, b_de_err, b_de_cnt;
        int b_fs_err, b_fs_cnt;
        int eh, ev;

        a_pos_err = 0; a_de_cnt = 0; a_de_last = -1; a_hs_cnt = 0;
        a_hs_first = -1; a_hs_last = -1; a_vs_cnt = 0;
        b_pos_err = 0; b_hs_err = 0; b_hs_cnt = 0; b_vs_err = 0; b_vs_cnt = 0;
        b_de_err = 0; b_de_cnt = 0; b_fs_err = 0; b_fs_cnt = 0;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) tick();

        check("a_rst_hpos",  int'(u_if_a.hpos), 1055);
        check("a_rst_vpos",  int'(u_if_a.vpos), 524);
        check("a_rst_de",    int'(u_if_a.data_enable), 0);
        check("a_rst_hsync", int'(u_if_a.hsync), 1);
        check("a_rst_vsync", int'(u_if_a.vsync), 1);
        check("b_rst_hpos",  int'(u_if_b.hpos), 15);
        check("b_rst_vpos",  int'(u_if_b.vpos), 11);
        check("b_rst_hsync", int'(u_if_b.hsync), 0);
        check("b_rst_vsync", int'(u_if_b.vsync), 0);
`ifdef HVSYNC_FRAME_PULSE_EN
        check("a_rst_fs",    int'(u_if_a.frame_start), 0);
`endif

        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        check("a_first_hpos",  int'(u_if_a.hpos), 0);
        check("a_first_vpos",  int'(u_if_a.vpos), 0);
        check("a_first_de",    int'(u_if_a.data_enable), 1);
        check("a_first_hsync", int'(u_if_a.hsync), 1);
`ifdef HVSYNC_FRAME_PULSE_EN
        check("a_first_fs",    int'(u_if_a.frame_start), 1);
`endif

        // One full line on A; two full frames (384 clocks) on B in parallel
        for (int t = 0; t < 1056; t++) begin
            if (int'(u_if_a.hpos) != t || int'(u_if_a.vpos) != 0) a_pos_err++;
            if (u_if_a.data_enable) begin
                a_de_cnt++;
                a_de_last = t;
            end
            if (!u_if_a.hsync) begin
                a_hs_cnt++;
                if (a_hs_first < 0) a_hs_first = t;
                a_hs_last = t;
            end
            if (!u_if_a.vsync) a_vs_cnt++;

            if (t < 384) begin
                eh = t % 16;
                ev = (t / 16) % 12;
                if (int'(u_if_b.hpos) != eh || int'(u_if_b.vpos) != ev) b_pos_err++;
                if (u_if_b.hsync !== ((eh >= 11) && (eh <= 12))) b_hs_err++;
                if (u_if_b.hsync) b_hs_cnt++;
                if (u_if_b.vsync !== ((ev >= 8) && (ev <= 10))) b_vs_err++;
                if (u_if_b.vsync) b_vs_cnt++;
                if (u_if_b.data_enable !== ((eh < 8) && (ev < 6))) b_de_err++;
                if (u_if_b.data_enable) b_de_cnt++;
`ifdef HVSYNC_FRAME_PULSE_EN
                if (u_if_b.frame_start !== ((eh == 0) && (ev == 0))) b_fs_err++;
                if (u_if_b.frame_start) b_fs_cnt++;
`endif
            end
            tick();
        end

        check("a_line_pos_err", a_pos_err, 0);
        check("a_line_de_cnt",  a_de_cnt, 800);
        check("a_line_de_last", a_de_last, 799);
        check("a_line_hs_cnt",  a_hs_cnt, 30);
        check("a_line_hs_first", a_hs_first, 1010);
        check("a_line_hs_last", a_hs_last, 1039);
        check("a_line_vs_cnt",  a_vs_cnt, 0);
        check("a_wrap_hpos",    int'(u_if_a.hpos), 0);
        check("a_wrap_vpos",    int'(u_if_a.vpos), 1);

        check("b_pos_err", b_pos_err, 0);
        check("b_hs_err",  b_hs_err, 0);
        check("b_hs_cnt",  b_hs_cnt, 48);
        check("b_vs_err",  b_vs_err, 0);
        check("b_vs_cnt",  b_vs_cnt, 96);
        check("b_de_err",  b_de_err, 0);
        check("b_de_cnt",  b_de_cnt, 96);
`ifdef HVSYNC_FRAME_PULSE_EN
        check("b_fs_err",  b_fs_err, 0);
        check("b_fs_cnt",  b_fs_cnt, 2);
`endif

        // Mid-line reset on A: one-cycle pulse aborts the frame
        repeat (400) tick();
        check("a_mid_hpos", int'(u_if_a.hpos), 400);
        check("a_mid_vpos", int'(u_if_a.vpos), 1);
        check("a_mid_de",   int'(u_if_a.data_enable), 1);

        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("a_abort_hpos",  int'(u_if_a.hpos), 1055);
        check("a_abort_vpos",  int'(u_if_a.vpos), 524);
        check("a_abort_de",    int'(u_if_a.data_enable), 0);
        check("a_abort_hsync", int'(u_if_a.hsync), 1);
        check("a_abort_vsync", int'(u_if_a.vsync), 1);

        tick();
        check("a_restart_hpos", int'(u_if_a.hpos), 0);
        check("a_restart_vpos", int'(u_if_a.vpos), 0);
        check("a_restart_de",   int'(u_if_a.data_enable), 1);
`ifdef HVSYNC_FRAME_PULSE_EN
        check("a_restart_fs",   int'(u_if_a.frame_start), 1);
        tick();
        check("a_after_fs",     int'(u_if_a.frame_start), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
